// File: rtl/axi_lite_master_engine.sv
// AXI4-Lite master: single outstanding command in, AXI transaction out, response back.
// Includes a transaction watchdog and a synchronised interrupt rising-edge detector.
module axi_lite_master_engine #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 256
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic                            CMD_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
  input  logic [2:0]                      CMD_PROT,
  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic                            RSP_WRITE,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic                            RSP_TIMEOUT,
  output logic                            STAT_BUSY,
  output logic                            STAT_HUNG,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  input  logic                            INTR_IN,
  output logic                            INTR_PULSE
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = (C_TIMEOUT_CYCLES > 0) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((C_TIMEOUT_CYCLES > 0) ? C_TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RSP, S_HUNG
  } state_t;

  state_t                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, rsp_rdata_q;
  logic [STRB_W-1:0]               wstrb_q;
  logic [2:0]                      prot_q;
  logic                            wr_q, awvalid_q, wvalid_q, arvalid_q;
  logic                            rsp_write_q, rsp_to_q;
  logic [1:0]                      rsp_resp_q;
  logic [CNT_W-1:0]                wd_cnt_q;
  logic                            sync1_q, sync2_q, prev_q, pulse_q;
  logic                            cmd_fire, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                            active, timeout_hit, load_b, load_r, load_to;

  assign CMD_READY    = (state_q == S_IDLE) & ~M_AXI_ARESET;
  assign M_AXI_BREADY = (state_q == S_WRESP) | (state_q == S_HUNG);
  assign M_AXI_RREADY = (state_q == S_RDATA) | (state_q == S_HUNG);

  assign cmd_fire = CMD_VALID & CMD_READY;
  assign aw_hs    = awvalid_q & M_AXI_AWREADY;
  assign w_hs     = wvalid_q & M_AXI_WREADY;
  assign ar_hs    = arvalid_q & M_AXI_ARREADY;
  assign b_hs     = M_AXI_BVALID & M_AXI_BREADY;
  assign r_hs     = M_AXI_RVALID & M_AXI_RREADY;

  assign active = (state_q == S_WRITE) | (state_q == S_WRESP) |
                  (state_q == S_READ)  | (state_q == S_RDATA);
  assign timeout_hit = (C_TIMEOUT_CYCLES > 0) && active && (wd_cnt_q == TO_LAST);

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // A completing B/R beat outranks a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    load_b  = 1'b0;
    load_r  = 1'b0;
    load_to = 1'b0;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = CMD_WRITE ? S_WRITE : S_READ;
      S_WRITE: begin
        if (timeout_hit) begin
          state_d = S_RSP;
          load_to = 1'b1;
        end else if ((~awvalid_q | aw_hs) & (~wvalid_q | w_hs)) begin
          state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (b_hs) begin
          state_d = S_RSP;
          load_b  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_RSP;
          load_to = 1'b1;
        end
      end
      S_READ: begin
        if (timeout_hit) begin
          state_d = S_RSP;
          load_to = 1'b1;
        end else if (ar_hs) begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (r_hs) begin
          state_d = S_RSP;
          load_r  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_RSP;
          load_to = 1'b1;
        end
      end
      S_RSP:   if (RSP_READY) state_d = rsp_to_q ? S_HUNG : S_IDLE;
      S_HUNG:  state_d = S_HUNG;
      default: state_d = S_IDLE;
    endcase
  end

  // VALIDs clear only on their own handshake, so they survive a timeout into HUNG.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      wr_q        <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_to_q    <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q    <= CMD_ADDR;
        wdata_q   <= CMD_WDATA;
        wstrb_q   <= CMD_WSTRB;
        prot_q    <= CMD_PROT;
        wr_q      <= CMD_WRITE;
        awvalid_q <= CMD_WRITE;
        wvalid_q  <= CMD_WRITE;
        arvalid_q <= ~CMD_WRITE;
        wd_cnt_q  <= '0;
      end else begin
        if (aw_hs) awvalid_q <= 1'b0;
        if (w_hs)  wvalid_q  <= 1'b0;
        if (ar_hs) arvalid_q <= 1'b0;
        if (active) wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (load_b) begin
        rsp_write_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= M_AXI_BRESP;
        rsp_to_q    <= 1'b0;
      end else if (load_r) begin
        rsp_write_q <= 1'b0;
        rsp_rdata_q <= M_AXI_RDATA;
        rsp_resp_q  <= M_AXI_RRESP;
        rsp_to_q    <= 1'b0;
      end else if (load_to) begin
        rsp_write_q <= wr_q;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= 2'b10;
        rsp_to_q    <= 1'b1;
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= INTR_IN;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign RSP_VALID     = (state_q == S_RSP);
  assign RSP_WRITE     = rsp_write_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign RSP_TIMEOUT   = rsp_to_q;
  assign STAT_BUSY     = (state_q != S_IDLE);
  assign STAT_HUNG     = (state_q == S_HUNG);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = prot_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = prot_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign INTR_PULSE    = pulse_q;

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Directed bench for axi_lite_master_engine with a hand-driven AXI4-Lite slave.
module tb_axi_lite_master_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          stat_busy, stat_hung;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          intr_in, intr_pulse;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  axi_lite_master_engine #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb), .CMD_PROT(cmd_prot),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_WRITE(rsp_write),
    .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp), .RSP_TIMEOUT(rsp_timeout),
    .STAT_BUSY(stat_busy), .STAT_HUNG(stat_hung),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .INTR_IN(intr_in), .INTR_PULSE(intr_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait write: command cycle T, AW/W at T+1, B at T+2, response at T+3.
  task automatic wr_fast(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] r);
    awready = 1'b1; wready = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
    cmd_wstrb = 4'hF; cmd_prot = 3'b000;
    chk("wf_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("wf_awvalid", awvalid, 1);
    chk("wf_wvalid", wvalid, 1);
    chk("wf_awaddr", awaddr, a);
    chk("wf_wdata", wdata, d);
    chk("wf_wstrb", wstrb, 4'hF);
    chk("wf_busy_ready", {stat_busy, cmd_ready}, 2'b10);
    bvalid = 1'b1; bresp = r;
    tick();
    chk("wf_valids_drop", {awvalid, wvalid}, 2'b00);
    chk("wf_bready", bready, 1);
    chk("wf_no_rsp_yet", rsp_valid, 0);
    tick();
    bvalid = 1'b0;
    chk("wf_rsp_valid", rsp_valid, 1);
    chk("wf_rsp_write", rsp_write, 1);
    chk("wf_rsp_resp", rsp_resp, r);
    chk("wf_rsp_rdata", rsp_rdata, 0);
    chk("wf_rsp_timeout", rsp_timeout, 0);
    chk("wf_bready_off", bready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wf_idle_after", {rsp_valid, stat_busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; cmd_prot = '0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; intr_in = 0;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, intr_pulse, stat_busy, stat_hung}, 5'b0);
    chk("rst_regs", {awaddr, wdata, rsp_rdata}, 96'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", cmd_ready, 1);

    // 1: zero-wait write
    wr_fast(32'h4, 32'h12345678, 2'b00);

    // 2: AWREADY immediately, WREADY delayed to T+4
    awready = 1'b1; wready = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hCAFEF00D;
    cmd_wstrb = 4'h3; cmd_prot = 3'b001;
    tick();
    cmd_valid = 1'b0;
    chk("dw_t1_valids", {awvalid, wvalid}, 2'b11);
    chk("dw_awprot", awprot, 3'b001);
    tick();
    chk("dw_t2_valids", {awvalid, wvalid, bready}, 3'b010);
    tick();
    chk("dw_t3_valids", {awvalid, wvalid, bready}, 3'b010);
    tick();
    wready = 1'b1;
    chk("dw_t4_valids", {awvalid, wvalid, bready}, 3'b010);
    tick();
    wready = 1'b0;
    chk("dw_t5_bready", {wvalid, bready, rsp_valid}, 3'b010);
    bvalid = 1'b1; bresp = 2'b11;
    tick();
    bvalid = 1'b0;
    chk("dw_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1111);
    tick();
    chk("dw_single_rsp_a", rsp_valid, 0);
    tick();
    chk("dw_single_rsp_b", {rsp_valid, stat_busy}, 2'b00);
    rsp_ready = 1'b0;

    // 3: read with RRESP=SLVERR and response back-pressure
    arready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_prot = 3'b010;
    tick();
    cmd_valid = 1'b0;
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, 32'h4);
    chk("rd_arprot", arprot, 3'b010);
    chk("rd_no_aw", {awvalid, wvalid}, 2'b00);
    tick();
    arready = 1'b0;
    chk("rd_rready", {arvalid, rready}, 2'b01);
    rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
    tick();
    rvalid = 1'b0; rdata = 32'hDEADBEEF; rresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("rd_hold_valid", {rsp_valid, cmd_ready, rsp_write}, 3'b100);
      chk("rd_hold_rdata", rsp_rdata, 32'h12345678);
      chk("rd_hold_resp", rsp_resp, 2'b10);
      tick();
    end
    chk("rd_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_done", {rsp_valid, cmd_ready}, 2'b01);

    // 4: ARREADY never asserted -> watchdog, then HUNG
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_prot = 3'b000;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to_wait", {rsp_valid, arvalid}, 2'b01);
      tick();
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_resp", rsp_resp, 2'b10);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_arvalid", arvalid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hung_state", {stat_hung, stat_busy, cmd_ready}, 3'b110);
    chk("hung_arvalid", arvalid, 1);
    chk("hung_readies", {bready, rready, rsp_valid}, 3'b110);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("hung_ar_drop", arvalid, 0);
    rvalid = 1'b1; rdata = 32'h55AA55AA;
    tick();
    rvalid = 1'b0;
    chk("hung_beat_dropped", {rsp_valid, stat_hung}, 2'b01);
    tick();
    chk("hung_no_rsp", rsp_valid, 0);
    rst = 1'b1;
    #1;
    chk("hung_reset", {stat_hung, stat_busy, arvalid, cmd_ready}, 4'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("hung_recovered", cmd_ready, 1);

    // 5: reset while in WRESP with BVALID pending
    awready = 1'b1; wready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hA5A5A5A5;
    cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    bvalid = 1'b1; bresp = 2'b00;
    chk("mr_in_wresp", bready, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_outputs", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready, stat_busy}, 8'h0);
    bvalid = 1'b0;
    tick();
    chk("mr_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    tick();
    chk("mr_no_rsp_after", {rsp_valid, stat_busy}, 2'b00);
    wr_fast(32'h24, 32'h0BADF00D, 2'b00);

    // 6: interrupt edge detector
    intr_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (intr_pulse) pulses++;
      chk("irq_rise1", intr_pulse, (i == 3) ? 1'b1 : 1'b0);
    end
    intr_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (intr_pulse) pulses++;
      chk("irq_low", intr_pulse, 0);
    end
    intr_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (intr_pulse) pulses++;
      chk("irq_rise2", intr_pulse, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("irq_count", pulses, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
